spawn_in_stream_arbiter: RTL

//   Packet-aware round-robin arbiter in front of the OmpSs manager task-creation input.

---
 rtl/spawn_in_stream_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spawn_in_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spawn_in_stream_arbiter
// Description : Packet-aware round-robin arbiter that merges NUM_PORTS
//               accelerator spawn AXI-Stream masters into the single
//               spawn_in stream of the OmpSs manager. A granted source keeps
//               the output until the beat carrying s_tlast is accepted, so
//               packets are never interleaved. Every beat is tagged with the
//               index of its source on m_tid. The output side is fully
//               registered.
//
// Ports       : aclk                  clock, rising edge
//               interconnect_aresetn  asynchronous active-low reset
//               s_tvalid/s_tready     per-source handshake (NUM_PORTS bits)
//               s_tdata               source i at [i*DATA_WIDTH +: DATA_WIDTH]
//               s_tdest               source i at [i*3 +: 3]
//               s_tlast               per-source end of packet
//               m_tvalid/m_tready     merged output handshake
//               m_tid                 index of the source of the current beat
//               m_tdest/m_tdata       payload of the current beat
//               m_tlast               end of packet
//
// Revision    : 1.0 - initial release
// ============================================================================
module spawn_in_stream_arbiter #(
    parameter  int NUM_PORTS  = 16,
    parameter  int DATA_WIDTH = 64,
    localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            aclk,
    input  logic                            interconnect_aresetn,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*3-1:0]          s_tdest,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [ID_WIDTH-1:0]             m_tid,
    output logic [2:0]                      m_tdest,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tlast
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]          c_ST_IDLE   = 1'b0;
    localparam logic [0:0]          c_ST_LOCKED = 1'b1;
    localparam int                  c_DW        = ID_WIDTH + 1;
    localparam logic [ID_WIDTH:0]   c_NUM       = c_DW'(NUM_PORTS);
    localparam logic [ID_WIDTH-1:0] c_LAST_ID   = ID_WIDTH'(NUM_PORTS - 1);
    localparam logic [ID_WIDTH-1:0] c_ID_ONE    = ID_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [ID_WIDTH-1:0] r_grant;
    logic [ID_WIDTH-1:0] r_rr_ptr;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic                  w_req_any;
    logic [ID_WIDTH-1:0]   w_pick;
    logic [ID_WIDTH:0]     w_best_dist;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [2:0]            w_sel_dest;
    logic                  w_out_free;
    logic                  w_accept;

    // Distance of source idx from the round-robin pointer, going upward and
    // wrapping at NUM_PORTS. The requester with the smallest distance wins.
    // One extra bit of width keeps idx + NUM_PORTS from overflowing.
    function automatic logic [ID_WIDTH:0] f_rr_dist(
        input logic [ID_WIDTH:0] idx,
        input logic [ID_WIDTH:0] ptr
    );
        if (idx >= ptr) begin
            return idx - ptr;
        end
        return idx + c_NUM - ptr;
    endfunction

    // Round-robin pick: scan every source, keep the closest requester.
    always_comb begin
        w_req_any   = 1'b0;
        w_pick      = '0;
        w_best_dist = '1;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (s_tvalid[j] &&
                (!w_req_any || (f_rr_dist(c_DW'(j), {1'b0, r_rr_ptr}) < w_best_dist))) begin
                w_req_any   = 1'b1;
                w_pick      = ID_WIDTH'(j);
                w_best_dist = f_rr_dist(c_DW'(j), {1'b0, r_rr_ptr});
            end
        end
    end

    // The output register can take a new beat when it is empty or is being
    // drained in this very cycle.
    assign w_out_free = !m_tvalid || m_tready;

    // Granted-source multiplexer and per-source ready. Only the granted
    // source ever sees ready, and only while the arbiter is locked.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_dest  = '0;
        s_tready    = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (r_grant == ID_WIDTH'(j)) begin
                w_sel_valid = s_tvalid[j];
                w_sel_last  = s_tlast[j];
                w_sel_data  = s_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                w_sel_dest  = s_tdest[j*3 +: 3];
                s_tready[j] = (r_state == c_ST_LOCKED) && w_out_free;
            end
        end
    end

    assign w_accept = (r_state == c_ST_LOCKED) && w_sel_valid && w_out_free;

    // ------------------------------------------------------------------------
    // Arbitration FSM and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge interconnect_aresetn) begin
        if (!interconnect_aresetn) begin
            r_state  <= c_ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            m_tvalid <= 1'b0;
            m_tid    <= '0;
            m_tdest  <= '0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Arbitration takes its own cycle; the first beat of the
                    // winner is accepted in the following one.
                    if (w_req_any) begin
                        r_grant <= w_pick;
                        r_state <= c_ST_LOCKED;
                    end
                end
                c_ST_LOCKED: begin
                    // Grant is held through s_tvalid gaps until the last
                    // beat of the packet has been taken.
                    if (w_accept && w_sel_last) begin
                        r_state  <= c_ST_IDLE;
                        r_rr_ptr <= (r_grant == c_LAST_ID) ? '0 : (r_grant + c_ID_ONE);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            if (w_accept) begin
                m_tvalid <= 1'b1;
                m_tid    <= r_grant;
                m_tdest  <= w_sel_dest;
                m_tdata  <= w_sel_data;
                m_tlast  <= w_sel_last;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
